// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_we,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);
    // Handshake: a requester holds req and its payload until it sees gnt in the same
    // cycle; gnt only rises at an arbitration point (IDLE, or BUSY with mem_ready).
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                arb_point;
    logic                win_if;
    logic                win_dm;

    always_comb begin
        arb_point = (state_q == IDLE) || mem_ready;
        win_if    = 1'b0;
        win_dm    = 1'b0;
        if (arb_point) begin
            if (if_req && (starve_cnt_q == CNT_W'(STARVE_MAX))) begin
                win_if = 1'b1;
            end else if (dm_req) begin
                win_dm = 1'b1;
            end else if (if_req) begin
                win_if = 1'b1;
            end
        end

        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        if_rvalid_d  = 1'b0;
        dm_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        // Completion of the in-flight access; a ready seen in IDLE belongs to nobody.
        if ((state_q == BUSY_IF) && mem_ready) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
        end
        if ((state_q == BUSY_DM) && mem_ready) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata;
        end

        if (win_if) begin
            state_d      = BUSY_IF;
            starve_cnt_d = '0;
            mem_req_d    = 1'b1;
            mem_addr_d   = if_addr;
            mem_we_d     = 4'b0000;
            mem_wdata_d  = '0;
        end else if (win_dm) begin
            state_d     = BUSY_DM;
            mem_req_d   = 1'b1;
            mem_addr_d  = dm_addr;
            mem_we_d    = dm_we;
            mem_wdata_d = dm_wdata;
            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (arb_point) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 4'b0000;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rvalid_q  <= if_rvalid_d;
            dm_rvalid_q  <= dm_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Grants are combinational, so they are masked while reset is held.
    assign if_gnt    = win_if & rst_n;
    assign dm_gnt    = win_dm & rst_n;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-scenario tasks with inline checks plus
// a response scoreboard that pops expected {is_dm, rdata} entries on every rvalid pulse.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_we;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W:0] exp_q[$];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        logic [DATA_W:0] e;
        if (rst_n === 1'b1 && (if_rvalid === 1'b1 || dm_rvalid === 1'b1)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: if_rvalid=%b dm_rvalid=%b with no expected response", if_rvalid, dm_rvalid);
            end else begin
                e = exp_q.pop_front();
                if ({dm_rvalid, (dm_rvalid ? dm_rdata : if_rdata)} !== e || (if_rvalid && dm_rvalid)) begin
                    n_err++;
                    $display("FAIL sb_resp: got if_rv=%b dm_rv=%b if_rdata=%h dm_rdata=%h, expected is_dm=%b data=%h",
                             if_rvalid, dm_rvalid, if_rdata, dm_rdata, e[DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_addr = 32'h88;
        dm_we = 4'hF; dm_wdata = 32'h1; mem_ready = 1'b1; mem_rdata = 32'h99;
        smp(); smp();
        n_vec++;
        if ({if_gnt, dm_gnt, mem_req, if_rvalid, dm_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: gnt/req/rvalid=%b expected 00000", {if_gnt, dm_gnt, mem_req, if_rvalid, dm_rvalid});
        end
        n_vec++;
        if (mem_addr !== 32'h0 || mem_we !== 4'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h we=%h wdata=%h if_rdata=%h dm_rdata=%h expected all 0",
                     mem_addr, mem_we, mem_wdata, if_rdata, dm_rdata);
        end
        cyc();
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
        smp();
    endtask

    task automatic test_single_load();
        cyc();
        dm_req = 1'b1; dm_addr = 32'h100; dm_we = 4'h0; dm_wdata = 32'h0;
        smp();
        n_vec++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            n_err++; $display("FAIL load_gnt: dm_gnt=%b if_gnt=%b expected 1 0", dm_gnt, if_gnt);
        end
        // Requester moves on after grant; in-flight access must not follow.
        cyc();
        dm_req = 1'b0; dm_addr = 32'h999;
        smp();
        for (int i = 1; i <= 3; i++) begin
            n_vec++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 4'h0 || dm_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL load_hold t+%0d: req=%b addr=%h we=%h dm_gnt=%b expected 1 100 0 0", i, mem_req, mem_addr, mem_we, dm_gnt);
            end
            if (i == 2) begin
                cyc();
                mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
                exp_q.push_back({1'b1, 32'hDEADBEEF});
                smp();
            end else if (i == 1) begin
                cyc(); smp();
            end
        end
        cyc();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        smp();
        n_vec++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL load_resp: dm_rvalid=%b dm_rdata=%h mem_req=%b expected 1 deadbeef 0", dm_rvalid, dm_rdata, mem_req);
        end
        cyc(); smp();
        n_vec++;
        if (dm_rvalid !== 1'b0) begin
            n_err++; $display("FAIL load_pulse: dm_rvalid=%b expected 0 at t+5", dm_rvalid);
        end
    endtask

    task automatic test_simultaneous();
        cyc();
        if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_addr = 32'h200; dm_we = 4'b0011; dm_wdata = 32'h77;
        smp();
        n_vec++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            n_err++; $display("FAIL simul_first: dm_gnt=%b if_gnt=%b expected 1 0", dm_gnt, if_gnt);
        end
        cyc();
        dm_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A50001;
        exp_q.push_back({1'b1, 32'hA5A50001});
        smp();
        n_vec++;
        if (mem_we !== 4'b0011 || mem_addr !== 32'h200 || if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL simul_handover: we=%b addr=%h if_gnt=%b dm_gnt=%b expected 0011 200 1 0", mem_we, mem_addr, if_gnt, dm_gnt);
        end
        cyc();
        if_req = 1'b0; mem_ready = 1'b0;
        smp();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 4'b0000 || mem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL simul_fetch: req=%b addr=%h we=%b wdata=%h expected 1 0 0000 0", mem_req, mem_addr, mem_we, mem_wdata);
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        exp_q.push_back({1'b0, 32'h11112222});
        smp();
        cyc();
        mem_ready = 1'b0;
        smp();
        n_vec++;
        if (mem_req !== 1'b0 || if_rvalid !== 1'b1) begin
            n_err++; $display("FAIL simul_done: mem_req=%b if_rvalid=%b expected 0 1", mem_req, if_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] pat;
        logic [DATA_W-1:0] rd;
        pat = 10'b1000010000;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'h1000 + i; dm_req = 1'b1; dm_addr = 32'h2000 + i; dm_we = 4'h0;
            mem_ready = 1'b1;
            rd = $urandom();
            mem_rdata = rd;
            if (i > 0) exp_q.push_back({~pat[i-1], rd});
            smp();
            n_vec++;
            if (if_gnt !== pat[i] || dm_gnt !== ~pat[i] || (i > 0 && mem_req !== 1'b1)) begin
                n_err++;
                $display("FAIL starve_seq[%0d]: if_gnt=%b dm_gnt=%b mem_req=%b expected if_gnt=%b", i, if_gnt, dm_gnt, mem_req, pat[i]);
            end
        end
        cyc();
        if_req = 1'b0; dm_req = 1'b0;
        rd = $urandom();
        mem_rdata = rd;
        exp_q.push_back({~pat[9], rd});
        smp();
        cyc();
        mem_ready = 1'b0;
        smp();
        n_vec++;
        if (mem_req !== 1'b0 || if_rvalid !== 1'b1) begin
            n_err++; $display("FAIL starve_drain: mem_req=%b if_rvalid=%b expected 0 1", mem_req, if_rvalid);
        end
    endtask

    task automatic test_store();
        cyc();
        dm_req = 1'b1; dm_addr = 32'h300; dm_we = 4'b1111; dm_wdata = 32'h12345678;
        smp();
        n_vec++;
        if (dm_gnt !== 1'b1) begin
            n_err++; $display("FAIL store_gnt: dm_gnt=%b expected 1", dm_gnt);
        end
        cyc();
        dm_req = 1'b0; dm_wdata = 32'hFFFF0000;
        smp();
        n_vec++;
        if (mem_wdata !== 32'h12345678 || mem_we !== 4'b1111 || mem_addr !== 32'h300) begin
            n_err++;
            $display("FAIL store_mem: wdata=%h we=%b addr=%h expected 12345678 1111 300", mem_wdata, mem_we, mem_addr);
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0000;
        exp_q.push_back({1'b1, 32'hCAFE0000});
        smp();
        n_vec++;
        if (mem_wdata !== 32'h12345678) begin
            n_err++; $display("FAIL store_hold: wdata=%h expected 12345678", mem_wdata);
        end
        cyc();
        mem_ready = 1'b0;
        smp();
        n_vec++;
        if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
            n_err++; $display("FAIL store_resp: dm_rvalid=%b if_rvalid=%b expected 1 0", dm_rvalid, if_rvalid);
        end
        cyc(); smp();
        n_vec++;
        if (dm_rvalid !== 1'b0) begin
            n_err++; $display("FAIL store_pulse: dm_rvalid=%b expected 0", dm_rvalid);
        end
    endtask

    task automatic test_spurious_ready();
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_ready = 1'b1; mem_rdata = 32'hBAD0 + i;
            smp();
            n_vec++;
            if (mem_req !== 1'b0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL spurious[%0d]: mem_req=%b if_rv=%b dm_rv=%b gnts=%b%b expected all 0",
                         i, mem_req, if_rvalid, dm_rvalid, if_gnt, dm_gnt);
            end
        end
        cyc();
        mem_ready = 1'b0;
        smp();
    endtask

    task automatic test_reset_mid();
        cyc();
        if_req = 1'b1; if_addr = 32'h40;
        smp();
        n_vec++;
        if (if_gnt !== 1'b1) begin
            n_err++; $display("FAIL rstmid_gnt: if_gnt=%b expected 1", if_gnt);
        end
        cyc();
        if_req = 1'b0;
        smp();
        cyc();
        rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BAD0BAD;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || if_rvalid !== 1'b0 || mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_async: mem_req=%b if_rvalid=%b addr=%h expected 0 0 0", mem_req, if_rvalid, mem_addr);
        end
        cyc();
        rst_n = 1'b1; mem_ready = 1'b0; dm_req = 1'b1; dm_addr = 32'h500; dm_we = 4'h0;
        smp();
        n_vec++;
        if (dm_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_regrant: dm_gnt=%b if_rvalid=%b expected 1 0", dm_gnt, if_rvalid);
        end
        cyc();
        dm_req = 1'b0;
        smp();
        n_vec++;
        if (mem_addr !== 32'h500 || mem_req !== 1'b1) begin
            n_err++; $display("FAIL rstmid_addr: addr=%h req=%b expected 500 1", mem_addr, mem_req);
        end
        cyc();
        mem_ready = 1'b1; mem_rdata = 32'h000055AA;
        exp_q.push_back({1'b1, 32'h000055AA});
        smp();
        cyc();
        mem_ready = 1'b0;
        smp();
        cyc(); smp();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_simultaneous();
        test_starvation();
        test_store();
        test_spurious_ready();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: %0d expected responses never arrived", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: bench did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the core's single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores carried over the EX→MEM boundary). Data accesses have priority, with a starvation guard that forces a fetch grant after a bounded run of data grants. Each access is one request/grant handshake toward the requester, a registered request held to the memory until `mem_ready`, and a one-cycle registered response pulse back to the owner.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (≥1)

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: fetch accepted this cycle (combinational)
- `if_rvalid` out 1: one-cycle fetch response pulse
- `if_rdata` out DATA_W: fetch data, valid with `if_rvalid`
- `dm_req` in 1: data request; held with address, byte mask and write data until `dm_gnt`
- `dm_addr` in ADDR_W: data address
- `dm_we` in 4: byte write mask; 0 = load
- `dm_wdata` in DATA_W: store data
- `dm_gnt` out 1: data accepted this cycle (combinational)
- `dm_rvalid` out 1: one-cycle completion pulse (loads and stores)
- `dm_rdata` out DATA_W: load data, valid with `dm_rvalid`
- `mem_req` out 1: memory request, registered
- `mem_addr` out ADDR_W: registered address
- `mem_we` out 4: registered byte mask; forced 0 for fetches
- `mem_wdata` out DATA_W: registered store data
- `mem_ready` in 1: memory completes current access this cycle
- `mem_rdata` in DATA_W: read data, valid with `mem_ready`

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- Arbitration point: any cycle in IDLE, or a BUSY cycle with `mem_ready`=1.
- Winner: fetch if `if_req` && `starve_cnt`==STARVE_MAX; else data if `dm_req`; else fetch if `if_req`; else none.
- At most one of `if_gnt`/`dm_gnt` high; never high outside an arbitration point.
- On grant: latch addr/we/wdata into `mem_*` (fetch: `mem_we`=0, `mem_wdata`=0), set `mem_req`=1, go to BUSY_IF/BUSY_DM.
- At arbitration point with no winner: `mem_req`←0, go to IDLE.
- `starve_cnt` (width clog2(STARVE_MAX+1)): +1 on data grant while `if_req`=1; cleared on fetch grant or on data grant while `if_req`=0; saturates at STARVE_MAX.
- `mem_ready` in BUSY_x: capture `mem_rdata` into `x_rdata`, pulse `x_rvalid` next cycle. For stores `dm_rdata` = captured `mem_rdata` (don't-care).
- `mem_ready` in IDLE: ignored, no pulse.
- Requester signal changes after grant have no effect on the in-flight access.

## Timing
- Reset values: state IDLE, `starve_cnt`=0, `mem_req`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `if_rvalid`=`dm_rvalid`=0, `if_rdata`=`dm_rdata`=0; gnts 0 while reset asserted.
- Grant at cycle t → `mem_req`/`mem_*` valid from t+1, held stable until the `mem_ready` cycle.
- `mem_ready` at cycle r → `x_rvalid`=1 only in r+1; a back-to-back grant in r drives the new `mem_*` from r+1 (`mem_req` stays 1).
- Minimum access: grant t, `mem_ready` t+1, rvalid t+2; back-to-back throughput one access per cycle when memory is zero-wait.
- Reset asserted mid-access: immediate return to reset values; in-flight access abandoned, no rvalid issued for it.

## Test plan
- Single load: `dm_req`, `dm_addr`=0x100, `dm_we`=0 at t; `mem_ready`, `mem_rdata`=0xDEADBEEF at t+3 → `dm_gnt` at t, `mem_addr`=0x100 t+1..t+3, `dm_rvalid`/`dm_rdata`=0xDEADBEEF at t+4 only, `mem_req`=0 at t+4.
- Simultaneous requests: `if_addr`=0x0, `dm_addr`=0x200, `dm_we`=4'b0011 → data first (`mem_we`=0011), then on its `mem_ready` `if_gnt` same cycle, `mem_addr`=0x0, `mem_we`=0 next cycle.
- Starvation: `if_req` and `dm_req` held high, zero-wait memory, STARVE_MAX=4 → grant sequence D,D,D,D,F,D,D,D,D,F.
- Store completion: `dm_we`=4'b1111, `dm_wdata`=0x12345678 → `mem_wdata`=0x12345678 until `mem_ready`; `dm_rvalid` pulses once, `if_rvalid` stays 0.
- Spurious ready: `mem_ready`=1 in IDLE, no requests → no rvalid, `mem_req` stays 0.
- Reset mid-access: drop `rst_n` two cycles after a fetch grant → `mem_req`, `if_rvalid` 0 immediately; after release, a new `dm_req` is granted in the first active cycle.
